// File: rtl/midi_voice_allocator_pkg.sv
// Shared definitions for the MIDI voice allocator.
//   NOTE_LOW / NOTE_HIGH : playable pitch window (C3..B4)
//   OFFSET_INVALID       : semitone offset marking an unusable pitch / empty voice
//   offset_t             : 5-bit semitone offset type
//   alloc_state_t        : allocator FSM states
package synth_pkg;

    localparam logic [7:0] NOTE_LOW  = 8'd48;
    localparam logic [7:0] NOTE_HIGH = 8'd71;

    typedef logic [4:0] offset_t;

    localparam offset_t OFFSET_INVALID = 5'd24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ASSIGN = 2'd2
    } alloc_state_t;

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Note event channel from the MIDI event decoder to the voice allocator.
//   valid    : event present (held by the sender until accepted)
//   ready    : allocator can accept an event
//   note_on  : 1 = note-on, 0 = note-off
//   pitch    : MIDI note number
//   velocity : MIDI velocity (0 on a note-on means note-off)
interface midi_voice_allocator_if;

    logic       valid;
    logic       ready;
    logic       note_on;
    logic [7:0] pitch;
    logic [6:0] velocity;

    // Event sender (decoder side)
    modport master (
        output valid,
        output note_on,
        output pitch,
        output velocity,
        input  ready
    );

    // Event receiver (allocator side)
    modport slave (
        input  valid,
        input  note_on,
        input  pitch,
        input  velocity,
        output ready
    );

endinterface

// File: rtl/midi_voice_allocator_lookup.sv
// Combinational pitch-to-semitone-offset conversion.
//   pitch  : MIDI note number
//   offset : pitch - NOTE_LOW inside NOTE_LOW..NOTE_HIGH, OFFSET_INVALID otherwise
module note_offset_lookup
    import synth_pkg::*;
(
    input  logic [7:0] pitch,
    output offset_t    offset
);

    logic [7:0] diff_s;

    assign diff_s = pitch - NOTE_LOW;

    // Range check; in-range differences are at most 23, so 5 bits suffice
    always_comb begin
        if ((pitch >= NOTE_LOW) && (pitch <= NOTE_HIGH)) begin
            offset = diff_s[4:0];
        end else begin
            offset = OFFSET_INVALID;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: takes note events and assigns them to voice slots
// (retrigger > lowest free voice > steal oldest), releasing voices on note-off.
//   clk, reset     : clock and synchronous active-high reset
//   ev             : note event channel (slave side)
//   voice_gate     : voice i sounding
//   voice_offset   : voice i semitone offset, slice [5i+4:5i]
//   voice_velocity : voice i velocity, slice [7i+6:7i]
//   voice_trigger  : one-cycle pulse, voice i (re)started
//   steal          : one-cycle pulse, a gated voice was taken over
//   dropped        : one-cycle pulse, event pitch out of range
module midi_voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    midi_voice_allocator_if.slave   ev,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [5*NUM_VOICES-1:0] voice_offset,
    output logic [7*NUM_VOICES-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]   voice_trigger,
    output logic                    steal,
    output logic                    dropped
);

    localparam int RW = $clog2(NUM_VOICES);

    alloc_state_t          state_r;
    logic                  ev_note_on_r;
    logic [7:0]            ev_pitch_r;
    logic [6:0]            ev_vel_r;
    offset_t               ev_offset_r;
    offset_t               lookup_offset_s;

    logic [NUM_VOICES-1:0] gate_r;
    logic [NUM_VOICES-1:0] trigger_r;
    offset_t               voice_off_r [NUM_VOICES];
    logic [6:0]            voice_vel_r [NUM_VOICES];
    logic [RW-1:0]         rank_r      [NUM_VOICES];
    logic                  steal_r;
    logic                  dropped_r;

    logic [NUM_VOICES-1:0] match_hit_s;
    logic [RW-1:0]         match_idx_s;
    logic [RW-1:0]         free_idx_s;
    logic [RW-1:0]         oldest_idx_s;
    logic [RW-1:0]         chosen_idx_s;
    logic                  steal_s;
    logic                  is_note_on_s;

    note_offset_lookup u_lookup (
        .pitch  (ev_pitch_r),
        .offset (lookup_offset_s)
    );

    assign ev.ready = (state_r == IDLE) && !reset;

    // A zero-velocity note-on is a note-off
    assign is_note_on_s = ev_note_on_r && (ev_vel_r != 7'd0);

    // Matching-offset hit vector over the gated voices
    always_comb begin
        match_hit_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match_hit_s[i] = gate_r[i] && (voice_off_r[i] == ev_offset_r);
        end
    end

    // Priority encoders: scanning downward leaves the lowest-index hit
    always_comb begin
        match_idx_s  = '0;
        free_idx_s   = '0;
        oldest_idx_s = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match_idx_s  = match_hit_s[i] ? RW'(i) : match_idx_s;
            free_idx_s   = !gate_r[i] ? RW'(i) : free_idx_s;
            oldest_idx_s = (rank_r[i] == RW'(NUM_VOICES - 1)) ? RW'(i) : oldest_idx_s;
        end
    end

    // Note-on target: retrigger, else free voice, else steal the oldest
    always_comb begin
        chosen_idx_s = oldest_idx_s;
        steal_s      = 1'b0;
        if (|match_hit_s) begin
            chosen_idx_s = match_idx_s;
        end else if (!(&gate_r)) begin
            chosen_idx_s = free_idx_s;
        end else begin
            chosen_idx_s = oldest_idx_s;
            steal_s      = 1'b1;
        end
    end

    // Allocator FSM with all voice state and registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            ev_note_on_r <= 1'b0;
            ev_pitch_r   <= 8'd0;
            ev_vel_r     <= 7'd0;
            ev_offset_r  <= OFFSET_INVALID;
            gate_r       <= '0;
            trigger_r    <= '0;
            steal_r      <= 1'b0;
            dropped_r    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_off_r[i] <= OFFSET_INVALID;
                voice_vel_r[i] <= 7'd0;
                rank_r[i]      <= RW'(i);
            end
        end else begin
            trigger_r <= '0;
            steal_r   <= 1'b0;
            dropped_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ev.valid && ev.ready) begin
                        ev_note_on_r <= ev.note_on;
                        ev_pitch_r   <= ev.pitch;
                        ev_vel_r     <= ev.velocity;
                        state_r      <= LOOKUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOOKUP: begin
                    ev_offset_r <= lookup_offset_s;
                    state_r     <= ASSIGN;
                end
                ASSIGN: begin
                    state_r <= IDLE;
                    if (ev_offset_r == OFFSET_INVALID) begin
                        dropped_r <= 1'b1;
                    end else if (is_note_on_s) begin
                        gate_r[chosen_idx_s]      <= 1'b1;
                        voice_off_r[chosen_idx_s] <= ev_offset_r;
                        voice_vel_r[chosen_idx_s] <= ev_vel_r;
                        trigger_r[chosen_idx_s]   <= 1'b1;
                        steal_r                   <= steal_s;
                        // Chosen voice becomes newest; younger voices age by one
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (RW'(i) == chosen_idx_s) begin
                                rank_r[i] <= '0;
                            end else if (rank_r[i] < rank_r[chosen_idx_s]) begin
                                rank_r[i] <= rank_r[i] + RW'(1);
                            end else begin
                                rank_r[i] <= rank_r[i];
                            end
                        end
                    end else if (|match_hit_s) begin
                        // Offset/velocity hold for the release phase
                        gate_r[match_idx_s] <= 1'b0;
                    end else begin
                        gate_r <= gate_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign voice_gate    = gate_r;
    assign voice_trigger = trigger_r;
    assign steal         = steal_r;
    assign dropped       = dropped_r;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_flatten
        assign voice_offset[5*gi +: 5]   = voice_off_r[gi];
        assign voice_velocity[7*gi +: 7] = voice_vel_r[gi];
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed self-checking bench for midi_voice_allocator (NUM_VOICES = 4).
module tb_midi_voice_allocator;

    logic        clk;
    logic        reset;
    logic [3:0]  voice_gate;
    logic [19:0] voice_offset;
    logic [27:0] voice_velocity;
    logic [3:0]  voice_trigger;
    logic        steal;
    logic        dropped;

    int n_checks;
    int n_errors;

    midi_voice_allocator_if ev_if ();

    midi_voice_allocator #(.NUM_VOICES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ev             (ev_if),
        .voice_gate     (voice_gate),
        .voice_offset   (voice_offset),
        .voice_velocity (voice_velocity),
        .voice_trigger  (voice_trigger),
        .steal          (steal),
        .dropped        (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] off_of(input int i);
        return voice_offset[5*i +: 5];
    endfunction

    function automatic logic [6:0] vel_of(input int i);
        return voice_velocity[7*i +: 7];
    endfunction

    // Reset for two cycles, check reset values, release reset
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ev_if.ready), 32'd0);
        check_eq("rst_gate", 32'(voice_gate), 32'd0);
        check_eq("rst_offset", 32'(voice_offset), 32'h000C6318);
        check_eq("rst_vel", 32'(voice_velocity), 32'd0);
        check_eq("rst_pulses", {29'd0, |voice_trigger, steal, dropped}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_release_ready", 32'(ev_if.ready), 32'd1);
    endtask

    // Send one event; returns #1 after the edge where results become visible
    task automatic send_event(input logic on, input logic [7:0] p, input logic [6:0] v);
        int n;
        n = 0;
        @(negedge clk);
        ev_if.valid    = 1'b1;
        ev_if.note_on  = on;
        ev_if.pitch    = p;
        ev_if.velocity = v;
        while (!ev_if.ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", 32'(ev_if.ready), 32'd1);
        @(posedge clk);
        #1;
        ev_if.valid = 1'b0;
        check_eq("ready_lookup", 32'(ev_if.ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("ready_assign", 32'(ev_if.ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("ready_back", 32'(ev_if.ready), 32'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        ev_if.valid    = 1'b0;
        ev_if.note_on  = 1'b0;
        ev_if.pitch    = 8'd0;
        ev_if.velocity = 7'd0;

        // Basic note-on to the first free voice
        do_reset();
        send_event(1'b1, 8'd60, 7'd100);
        check_eq("t1_gate", 32'(voice_gate), 32'h1);
        check_eq("t1_off0", 32'(off_of(0)), 32'd12);
        check_eq("t1_vel0", 32'(vel_of(0)), 32'd100);
        check_eq("t1_trig", 32'(voice_trigger), 32'h1);
        check_eq("t1_steal", 32'(steal), 32'd0);
        next_cycle();
        check_eq("t1_trig_width", 32'(voice_trigger), 32'h0);

        // Fill all voices then steal the oldest
        do_reset();
        send_event(1'b1, 8'd48, 7'd10);
        send_event(1'b1, 8'd50, 7'd11);
        send_event(1'b1, 8'd52, 7'd12);
        send_event(1'b1, 8'd55, 7'd13);
        check_eq("t2_full_gate", 32'(voice_gate), 32'hF);
        check_eq("t2_trig3", 32'(voice_trigger), 32'h8);
        check_eq("t2_no_steal", 32'(steal), 32'd0);
        send_event(1'b1, 8'd57, 7'd14);
        check_eq("t2_steal", 32'(steal), 32'd1);
        check_eq("t2_trig", 32'(voice_trigger), 32'h1);
        check_eq("t2_off0", 32'(off_of(0)), 32'd9);
        check_eq("t2_vel0", 32'(vel_of(0)), 32'd14);
        next_cycle();
        check_eq("t2_steal_width", 32'(steal), 32'd0);
        // Ages now v1 oldest, then v2
        send_event(1'b1, 8'd59, 7'd15);
        check_eq("t2_steal_v1", 32'(voice_trigger), 32'h2);
        check_eq("t2_off1", 32'(off_of(1)), 32'd11);
        send_event(1'b1, 8'd60, 7'd16);
        check_eq("t2_steal_v2", 32'(voice_trigger), 32'h4);
        check_eq("t2_off2", 32'(off_of(2)), 32'd12);

        // Retrigger, unmatched note-off, matching note-off
        do_reset();
        send_event(1'b1, 8'd64, 7'd90);
        check_eq("t3_off0", 32'(off_of(0)), 32'd16);
        send_event(1'b1, 8'd64, 7'd40);
        check_eq("t3_retrig", 32'(voice_trigger), 32'h1);
        check_eq("t3_retrig_gate", 32'(voice_gate), 32'h1);
        check_eq("t3_retrig_vel", 32'(vel_of(0)), 32'd40);
        check_eq("t3_retrig_steal", 32'(steal), 32'd0);
        send_event(1'b0, 8'd65, 7'd0);
        check_eq("t3_off65_gate", 32'(voice_gate), 32'h1);
        check_eq("t3_off65_trig", 32'(voice_trigger), 32'h0);
        send_event(1'b0, 8'd64, 7'd0);
        check_eq("t3_off64_gate", 32'(voice_gate), 32'h0);
        check_eq("t3_off64_hold", 32'(off_of(0)), 32'd16);
        check_eq("t3_off64_vel", 32'(vel_of(0)), 32'd40);

        // Out-of-range pitches and top of range
        do_reset();
        send_event(1'b1, 8'd47, 7'd50);
        check_eq("t4_drop47", 32'(dropped), 32'd1);
        check_eq("t4_drop47_trig", 32'(voice_trigger), 32'h0);
        check_eq("t4_drop47_gate", 32'(voice_gate), 32'h0);
        next_cycle();
        check_eq("t4_drop_width", 32'(dropped), 32'd0);
        send_event(1'b1, 8'd72, 7'd50);
        check_eq("t4_drop72", 32'(dropped), 32'd1);
        check_eq("t4_drop72_gate", 32'(voice_gate), 32'h0);
        check_eq("t4_drop72_steal", 32'(steal), 32'd0);
        send_event(1'b1, 8'd71, 7'd50);
        check_eq("t4_p71_off", 32'(off_of(0)), 32'd23);
        check_eq("t4_p71_drop", 32'(dropped), 32'd0);
        check_eq("t4_p71_trig", 32'(voice_trigger), 32'h1);

        // Zero-velocity note-on acts as note-off
        do_reset();
        send_event(1'b1, 8'd60, 7'd70);
        send_event(1'b1, 8'd62, 7'd71);
        check_eq("t5_gate_on", 32'(voice_gate), 32'h3);
        send_event(1'b1, 8'd62, 7'd0);
        check_eq("t5_gate_off", 32'(voice_gate), 32'h1);
        check_eq("t5_trig", 32'(voice_trigger), 32'h0);
        check_eq("t5_hold_off1", 32'(off_of(1)), 32'd14);

        // Reset during ASSIGN abandons the event
        @(negedge clk);
        ev_if.valid    = 1'b1;
        ev_if.note_on  = 1'b1;
        ev_if.pitch    = 8'd65;
        ev_if.velocity = 7'd33;
        check_eq("t6_ready", 32'(ev_if.ready), 32'd1);
        @(posedge clk);
        #1;
        ev_if.valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_gate", 32'(voice_gate), 32'h0);
        check_eq("t6_offset", 32'(voice_offset), 32'h000C6318);
        check_eq("t6_vel", 32'(voice_velocity), 32'd0);
        check_eq("t6_pulses", {29'd0, |voice_trigger, steal, dropped}, 32'd0);
        check_eq("t6_ready_rst", 32'(ev_if.ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6_ready_after", 32'(ev_if.ready), 32'd1);
        next_cycle();
        check_eq("t6_pulses_after", {29'd0, |voice_trigger, steal, dropped}, 32'd0);
        check_eq("t6_gate_after", 32'(voice_gate), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
